// File: rtl/unsigned_seq_multiplier.sv
// Unsigned shift-and-add multiplier: one add-then-shift step per clock, full 2*WIDTH-bit product.
// Latency: fixed WIDTH cycles after the accepting edge; rdy rises on the (WIDTH+1)th edge counting the accept.
// Backpressure: none; start is ignored while busy, and the result is held in DONE until the next accepted start.
module unsigned_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 rdy,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo
);

    // Counter is wide enough to reach WIDTH-1; a 1-bit floor keeps WIDTH=1 legal.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               load;
    logic               step;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      count;
    logic [WIDTH:0]     sum;

    // State register; reset returns to IDLE at once, aborting any multiply in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath strobes: accept only from IDLE/DONE, leave RUN after the last iteration.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count == LAST) begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Conditional add of the multiplicand into the upper half; the extra bit keeps the carry.
    always_comb begin
        sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
        if (prod[0]) begin
            sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end
    end

    // Datapath: capture operands on accept, otherwise add-and-shift once per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= '0;
            prod  <= '0;
            count <= '0;
        end else if (load) begin
            mcand <= multiplicand;
            prod  <= {{WIDTH{1'b0}}, multiplier};
            count <= '0;
        end else if (step) begin
            prod  <= {sum, prod[WIDTH-1:1]};
            count <= count + 1'b1;
        end
    end

    assign busy    = (state == RUN);
    assign rdy     = (state == DONE);
    assign product = prod;
    assign hi      = prod[2*WIDTH-1:WIDTH];
    assign lo      = prod[WIDTH-1:0];

endmodule
